// File: rtl/priority_decoder_latch_if.sv
// Bus between the priority encoder's consumer side and the decoder/latch block.
// The master drives the index/clear/select inputs; the slave returns decode, flags and counts.
interface priority_decoder_latch_if #(
  parameter int unsigned N_LINES = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned CNT_W   = 4
);
  logic [IDX_W-1:0]   in_idx;
  logic               in_valid;
  logic               clr_en;
  logic [N_LINES-1:0] clr_mask;
  logic [IDX_W-1:0]   cnt_sel;
  logic [N_LINES-1:0] out_onehot;
  logic               out_valid;
  logic [N_LINES-1:0] pending;
  logic [CNT_W-1:0]   cnt_out;
  logic               idx_err;
  logic               overflow;

  modport master (
    output in_idx, in_valid, clr_en, clr_mask, cnt_sel,
    input  out_onehot, out_valid, pending, cnt_out, idx_err, overflow
  );

  modport slave (
    input  in_idx, in_valid, clr_en, clr_mask, cnt_sel,
    output out_onehot, out_valid, pending, cnt_out, idx_err, overflow
  );
endinterface

// File: rtl/priority_decoder_latch.sv
// Regenerates the one-hot request line from an (index, valid) bus and keeps
// sticky per-line pending flags plus saturating per-line event counters.
module priority_decoder_latch #(
  parameter int unsigned N_LINES = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  priority_decoder_latch_if.slave bus
);
  localparam int unsigned N_IDX = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               accept_c;
  logic               err_c;
  logic               clr_all_c;
  logic               sat_hit_c;
  logic [N_LINES-1:0] dec_c;
  logic [N_LINES-1:0] clr_c;
  logic [CNT_W-1:0]   cnt_d [N_LINES];
  logic [CNT_W-1:0]   cnt_rd [N_IDX];

  logic [N_LINES-1:0] onehot_q;
  logic               valid_q;
  logic [N_LINES-1:0] pend_q;
  logic               idx_err_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q [N_LINES];

  // Input qualification and decode of the accepted index
  always_comb begin
    accept_c  = bus.in_valid && (32'(bus.in_idx) < N_LINES);
    err_c     = bus.in_valid && (32'(bus.in_idx) >= N_LINES);
    dec_c     = accept_c ? (N_LINES'(1) << bus.in_idx) : '0;
    clr_c     = bus.clr_en ? bus.clr_mask : '0;
    clr_all_c = bus.clr_en && (&bus.clr_mask);
  end

  // Counter next-state: clear first, then the event; a saturated counter holds
  always_comb begin
    sat_hit_c = 1'b0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_c[i]) begin
        cnt_d[i] = '0;
      end
      if (dec_c[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          sat_hit_c = 1'b1;
        end
        if (clr_c[i]) begin
          cnt_d[i] = CNT_W'(1);
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Read port padded to the full index space so unused selects read zero
  always_comb begin
    for (int unsigned i = 0; i < N_IDX; i++) begin
      cnt_rd[i] = '0;
    end
    for (int unsigned i = 0; i < N_LINES; i++) begin
      cnt_rd[i] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      pend_q    <= '0;
      idx_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      for (int unsigned i = 0; i < N_LINES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      onehot_q  <= dec_c;
      valid_q   <= accept_c;
      pend_q    <= dec_c | (pend_q & ~clr_c);
      idx_err_q <= err_c | (idx_err_q & ~clr_all_c);
      ovf_q     <= sat_hit_c | (ovf_q & ~clr_all_c);
      for (int unsigned i = 0; i < N_LINES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.out_onehot = onehot_q;
  assign bus.out_valid  = valid_q;
  assign bus.pending    = pend_q;
  assign bus.idx_err    = idx_err_q;
  assign bus.overflow   = ovf_q;
  assign bus.cnt_out    = cnt_rd[bus.cnt_sel];
endmodule

// File: tb/tb_priority_decoder_latch.sv
// Bench for priority_decoder_latch: a 4-line and a 3-line instance driven in parallel,
// each checked every cycle against a behavioural model of the line/flag rules.
module tb_priority_decoder_latch;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cur_sel  = 0;

  int   nl [2] = '{4, 3};
  int   m_cnt [2][16];
  int   m_pend [2];
  int   m_oh [2];
  bit   m_err [2];
  bit   m_ovf [2];

  always #5 clk = ~clk;

  priority_decoder_latch_if #(.N_LINES(4), .IDX_W(2), .CNT_W(CW)) b4 ();
  priority_decoder_latch_if #(.N_LINES(3), .IDX_W(2), .CNT_W(CW)) b3 ();

  priority_decoder_latch #(.N_LINES(4), .IDX_W(2), .CNT_W(CW)) u4 (
    .clk(clk), .rst(rst), .bus(b4.slave));
  priority_decoder_latch #(.N_LINES(3), .IDX_W(2), .CNT_W(CW)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
      m_pend[k] = 0;
      m_oh[k]   = 0;
      m_err[k]  = 1'b0;
      m_ovf[k]  = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model for instance k
  task automatic model_edge(input int k, input bit v, input int idx, input bit ce, input int mask);
    int n       = nl[k];
    int full    = (1 << n) - 1;
    bit ev      = v && (idx < n);
    bit allclr  = ce && ((mask & full) == full);
    bit hit     = ev && (m_cnt[k][idx] == CMAX);
    m_ovf[k] = (m_ovf[k] && !allclr) || hit;
    m_err[k] = (m_err[k] && !allclr) || (v && idx >= n);
    for (int i = 0; i < n; i++) begin
      if (ce && ((mask >> i) & 1) == 1) begin
        m_cnt[k][i] = 0;
        m_pend[k]   = m_pend[k] & ~(1 << i);
      end
    end
    if (ev) begin
      m_pend[k] = m_pend[k] | (1 << idx);
      if (m_cnt[k][idx] < CMAX) m_cnt[k][idx] = m_cnt[k][idx] + 1;
    end
    m_oh[k] = ev ? (1 << idx) : 0;
  endtask

  function automatic int exp_cnt(input int k);
    return (cur_sel < nl[k]) ? m_cnt[k][cur_sel] : 0;
  endfunction

  task automatic check_all();
    chk("d4_onehot",   32'(b4.out_onehot), 32'(m_oh[0]));
    chk("d4_valid",    32'(b4.out_valid),  32'(m_oh[0] != 0));
    chk("d4_pending",  32'(b4.pending),    32'(m_pend[0]));
    chk("d4_cnt_out",  32'(b4.cnt_out),    32'(exp_cnt(0)));
    chk("d4_idx_err",  32'(b4.idx_err),    32'(m_err[0]));
    chk("d4_overflow", 32'(b4.overflow),   32'(m_ovf[0]));
    chk("d3_onehot",   32'(b3.out_onehot), 32'(m_oh[1]));
    chk("d3_valid",    32'(b3.out_valid),  32'(m_oh[1] != 0));
    chk("d3_pending",  32'(b3.pending),    32'(m_pend[1]));
    chk("d3_cnt_out",  32'(b3.cnt_out),    32'(exp_cnt(1)));
    chk("d3_idx_err",  32'(b3.idx_err),    32'(m_err[1]));
    chk("d3_overflow", 32'(b3.overflow),   32'(m_ovf[1]));
  endtask

  task automatic drive(input bit v, input int idx, input bit ce, input int mask, input int sel);
    b4.in_valid = v;  b4.in_idx = 2'(idx);  b4.clr_en = ce;  b4.clr_mask = 4'(mask);  b4.cnt_sel = 2'(sel);
    b3.in_valid = v;  b3.in_idx = 2'(idx);  b3.clr_en = ce;  b3.clr_mask = 3'(mask);  b3.cnt_sel = 2'(sel);
    cur_sel = sel;
  endtask

  // Apply inputs, take one edge, advance the model and compare everything
  task automatic step(input bit v, input int idx, input bit ce, input int mask, input int sel);
    drive(v, idx, ce, mask, sel);
    @(posedge clk);
    #1;
    model_edge(0, v, idx, ce, mask);
    model_edge(1, v, idx, ce, mask);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 1'b0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single event on line 2, then idle: decode is not held
    step(1'b1, 2, 1'b0, 0, 2);
    chk("t1_onehot", 32'(b4.out_onehot), 32'h4);
    step(1'b0, 0, 1'b0, 0, 2);
    chk("t1_onehot_drop", 32'(b4.out_onehot), 32'h0);
    chk("t1_cnt2", 32'(b4.cnt_out), 32'd1);

    // Back-to-back stream
    step(1'b1, 0, 1'b0, 0, 3);
    step(1'b1, 1, 1'b0, 0, 3);
    step(1'b1, 3, 1'b0, 0, 3);
    chk("t2_onehot3", 32'(b4.out_onehot), 32'h8);
    step(1'b1, 3, 1'b0, 0, 3);
    chk("t2_cnt3", 32'(b4.cnt_out), 32'd2);
    step(1'b0, 0, 1'b0, 0, 3);

    // Saturation on line 1 and full clear
    step(1'b0, 0, 1'b1, 15, 1);
    for (int e = 0; e < 17; e++) step(1'b1, 1, 1'b0, 0, 1);
    chk("t3_cnt_sat", 32'(b4.cnt_out), 32'(CMAX));
    chk("t3_overflow", 32'(b4.overflow), 32'd1);
    step(1'b0, 0, 1'b1, 15, 1);
    chk("t3_ovf_clr", 32'(b4.overflow), 32'd0);

    // Set beats clear on the same edge
    step(1'b1, 2, 1'b0, 0, 2);
    step(1'b1, 2, 1'b1, 4, 2);
    chk("t4_pend_kept", 32'(b4.pending[2]), 32'd1);
    chk("t4_cnt_one", 32'(b4.cnt_out), 32'd1);
    step(1'b0, 0, 1'b1, 4, 2);
    chk("t4_pend_clr", 32'(b4.pending[2]), 32'd0);

    // Index 3 is out of range for the 3-line instance only
    step(1'b1, 3, 1'b0, 0, 3);
    chk("t5_d3_err", 32'(b3.idx_err), 32'd1);
    chk("t5_d3_valid", 32'(b3.out_valid), 32'd0);
    chk("t5_d3_cnt_sel3", 32'(b3.cnt_out), 32'd0);
    step(1'b0, 0, 1'b1, 15, 0);

    // Randomized traffic with occasional partial and full clears
    for (int r = 0; r < 400; r++) begin
      int rm;
      rm = (($urandom % 2) == 0) ? 15 : int'($urandom % 16);
      step(($urandom % 4) != 0, int'($urandom % 4), ($urandom % 8) == 0, rm, int'($urandom % 4));
    end

    // Asynchronous reset between edges while output is live
    step(1'b0, 0, 1'b1, 15, 0);
    for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, 0, 0);
    step(1'b1, 0, 1'b0, 0, 0);
    chk("t6_pend_full", 32'(b4.pending), 32'hf);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t6_async_valid", 32'(b4.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 0, 1'b0, 0, 0);
    chk("t6_first_after_rst", 32'(b4.out_onehot), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
